// File: rtl/axi_rd_pattern_slave.sv
`default_nettype none
// ============================================================================
// Module   : axi_rd_pattern_slave
// Function : AXI3 read-only responder; each beat returns its own word address.
//            Define AXI_RD_SLVERR_EN to answer illegal bursts with SLVERR.
// Revision : 1.0 - initial release
// ============================================================================
module axi_rd_pattern_slave #(
    parameter int AXI_WIDTH_ID       = 4,
    parameter int AXI_WIDTH_AD       = 32,
    parameter int P_DELAY_READ_SETUP = 0
) (
    input  logic                    ACLK,
    input  logic                    ARESETn,
    input  logic [AXI_WIDTH_ID-1:0] ARID,
    input  logic [AXI_WIDTH_AD-1:0] ARADDR,
    input  logic [3:0]              ARLEN,
    input  logic [2:0]              ARSIZE,
    input  logic [1:0]              ARBURST,
    input  logic                    ARVALID,
    output logic                    ARREADY,
    output logic [AXI_WIDTH_ID-1:0] RID,
    output logic [31:0]             RDATA,
    output logic [1:0]              RRESP,
    output logic                    RLAST,
    output logic                    RVALID,
    input  logic                    RREADY
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_BURST = 2'd2
    } state_t;

    localparam logic [1:0] c_burst_fixed = 2'b00;
    localparam logic [1:0] c_burst_wrap  = 2'b10;
    localparam logic [1:0] c_resp_okay   = 2'b00;
    localparam logic [1:0] c_resp_slverr = 2'b10;
    localparam logic [7:0] c_setup_last  = 8'(P_DELAY_READ_SETUP - 1);

    state_t                  state_q, state_d;
    logic [AXI_WIDTH_ID-1:0] id_q, id_d;
    logic [AXI_WIDTH_AD-1:0] addr_q, addr_d;
    logic [3:0]              len_q, len_d;
    logic [2:0]              size_q, size_d;
    logic [1:0]              burst_q, burst_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [7:0]              dly_q, dly_d;
    logic                    err_q, err_d;
    logic                    arready_q, arready_d;
    logic                    rvalid_q, rvalid_d;
    logic [AXI_WIDTH_ID-1:0] rid_q, rid_d;
    logic [31:0]             rdata_q, rdata_d;
    logic [1:0]              rresp_q, rresp_d;
    logic                    rlast_q, rlast_d;
    logic                    w_load;
    logic                    w_ar_err;

`ifdef AXI_RD_SLVERR_EN
    always_comb begin
        w_ar_err = (ARSIZE > 3'd2);
        if (ARBURST == c_burst_wrap) begin
            if (!(ARLEN inside {4'd1, 4'd3, 4'd7, 4'd15}))
                w_ar_err = 1'b1;
            if ((ARADDR & ((AXI_WIDTH_AD'(1) << ARSIZE) - AXI_WIDTH_AD'(1))) != '0)
                w_ar_err = 1'b1;
        end
    end
`else
    assign w_ar_err = 1'b0;
`endif

    // WRAP keeps the bits above the (ARLEN+1)<<ARSIZE window and wraps the rest
    function automatic logic [AXI_WIDTH_AD-1:0] f_next_addr(
        input logic [AXI_WIDTH_AD-1:0] addr,
        input logic [2:0]              size,
        input logic [3:0]              len,
        input logic [1:0]              burst
    );
        logic [AXI_WIDTH_AD-1:0] step;
        logic [AXI_WIDTH_AD-1:0] mask;
        step = AXI_WIDTH_AD'(1) << size;
        mask = ((AXI_WIDTH_AD'(len) + AXI_WIDTH_AD'(1)) << size) - AXI_WIDTH_AD'(1);
        if (burst == c_burst_fixed)
            f_next_addr = addr;
        else if (burst == c_burst_wrap)
            f_next_addr = (addr & ~mask) | ((addr + step) & mask);
        else
            f_next_addr = addr + step;
    endfunction

    function automatic logic [31:0] f_beat_data(input logic [AXI_WIDTH_AD-1:0] addr,
                                                input logic                    err);
        logic [31:0] d;
        d      = 32'(addr);
        d[1:0] = 2'b00;
        f_beat_data = err ? 32'd0 : d;
    endfunction

    always_comb begin
        state_d   = state_q;
        id_d      = id_q;
        addr_d    = addr_q;
        len_d     = len_q;
        size_d    = size_q;
        burst_d   = burst_q;
        cnt_d     = cnt_q;
        dly_d     = dly_q;
        err_d     = err_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rid_d     = rid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        rlast_d   = rlast_q;
        w_load    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                arready_d = 1'b1;
                if (ARVALID && arready_q) begin
                    id_d      = ARID;
                    addr_d    = ARADDR;
                    len_d     = ARLEN;
                    size_d    = ARSIZE;
                    burst_d   = ARBURST;
                    err_d     = w_ar_err;
                    cnt_d     = 4'd0;
                    dly_d     = 8'd0;
                    arready_d = 1'b0;
                    state_d   = (P_DELAY_READ_SETUP == 0) ? ST_BURST : ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (dly_q == c_setup_last)
                    state_d = ST_BURST;
                else
                    dly_d = dly_q + 8'd1;
            end
            ST_BURST: begin
                // The first BURST cycle only loads the output registers for beat 0
                if (!rvalid_q) begin
                    rvalid_d = 1'b1;
                    w_load   = 1'b1;
                end else if (RREADY) begin
                    if (rlast_q) begin
                        state_d   = ST_IDLE;
                        rvalid_d  = 1'b0;
                        rlast_d   = 1'b0;
                        rresp_d   = c_resp_okay;
                        arready_d = 1'b1;
                    end else begin
                        cnt_d  = cnt_q + 4'd1;
                        addr_d = f_next_addr(addr_q, size_q, len_q, burst_q);
                        w_load = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (w_load) begin
            rid_d   = id_q;
            rdata_d = f_beat_data(addr_d, err_q);
            rresp_d = err_q ? c_resp_slverr : c_resp_okay;
            rlast_d = (cnt_d == len_q);
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q   <= ST_IDLE;
            id_q      <= '0;
            addr_q    <= '0;
            len_q     <= 4'd0;
            size_q    <= 3'd0;
            burst_q   <= 2'b00;
            cnt_q     <= 4'd0;
            dly_q     <= 8'd0;
            err_q     <= 1'b0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rid_q     <= '0;
            rdata_q   <= 32'd0;
            rresp_q   <= 2'b00;
            rlast_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            id_q      <= id_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            size_q    <= size_d;
            burst_q   <= burst_d;
            cnt_q     <= cnt_d;
            dly_q     <= dly_d;
            err_q     <= err_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rid_q     <= rid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            rlast_q   <= rlast_d;
        end
    end

    assign ARREADY = arready_q;
    assign RVALID  = rvalid_q;
    assign RID     = rid_q;
    assign RDATA   = rdata_q;
    assign RRESP   = rresp_q;
    assign RLAST   = rlast_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_rd_pattern_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_rd_pattern_slave
// Function : directed table plus randomized bursts on two instances
//            (setup delay 0 and 3); honours AXI_RD_SLVERR_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_rd_pattern_slave;

    localparam int c_delay0 = 0;
    localparam int c_delay1 = 3;

    logic             clk;
    logic             rst_n;
    logic [3:0]       arid;
    logic [31:0]      araddr;
    logic [3:0]       arlen;
    logic [2:0]       arsize;
    logic [1:0]       arburst;
    logic [1:0]       arvalid;
    logic [1:0]       arready;
    logic [1:0][3:0]  rid;
    logic [1:0][31:0] rdata;
    logic [1:0][1:0]  rresp;
    logic [1:0]       rlast;
    logic [1:0]       rvalid;
    logic [1:0]       rready;

    int n_vec = 0;
    int n_bad = 0;

    logic [31:0] q_data[$];
    logic [1:0]  q_resp[$];
    logic        q_last[$];
    logic [3:0]  q_id[$];
    logic [31:0] e_data[16];
    logic [1:0]  e_resp;
    int          e_beats;

    axi_rd_pattern_slave #(
        .AXI_WIDTH_ID(4), .AXI_WIDTH_AD(32), .P_DELAY_READ_SETUP(c_delay0)
    ) u_dut0 (
        .ACLK(clk), .ARESETn(rst_n), .ARID(arid), .ARADDR(araddr), .ARLEN(arlen),
        .ARSIZE(arsize), .ARBURST(arburst), .ARVALID(arvalid[0]), .ARREADY(arready[0]),
        .RID(rid[0]), .RDATA(rdata[0]), .RRESP(rresp[0]), .RLAST(rlast[0]),
        .RVALID(rvalid[0]), .RREADY(rready[0])
    );

    axi_rd_pattern_slave #(
        .AXI_WIDTH_ID(4), .AXI_WIDTH_AD(32), .P_DELAY_READ_SETUP(c_delay1)
    ) u_dut1 (
        .ACLK(clk), .ARESETn(rst_n), .ARID(arid), .ARADDR(araddr), .ARLEN(arlen),
        .ARSIZE(arsize), .ARBURST(arburst), .ARVALID(arvalid[1]), .ARREADY(arready[1]),
        .RID(rid[1]), .RDATA(rdata[1]), .RRESP(rresp[1]), .RLAST(rlast[1]),
        .RVALID(rvalid[1]), .RREADY(rready[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string what, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", what, got, exp);
        end
    endtask

    function automatic int f_delay(input int u);
        return (u == 0) ? c_delay0 : c_delay1;
    endfunction

    // Reference beats straight from the burst rules, using wide integer arithmetic
    task automatic model(input logic [31:0] addr, input logic [3:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
        longint unsigned cur, step, wlen, base;
        bit err;
        err = 1'b0;
`ifdef AXI_RD_SLVERR_EN
        if (size > 3'd2) err = 1'b1;
        if (burst == 2'b10 && !(len == 4'd1 || len == 4'd3 || len == 4'd7 || len == 4'd15)) err = 1'b1;
        if (burst == 2'b10 && (longint'(addr) % (longint'(1) << size)) != 0) err = 1'b1;
`endif
        step    = longint'(1) << size;
        wlen    = (longint'(len) + 1) * step;
        cur     = longint'(addr);
        base    = cur - (cur % wlen);
        e_beats = int'(len) + 1;
        e_resp  = err ? 2'b10 : 2'b00;
        for (int b = 0; b < e_beats; b++) begin
            e_data[b] = err ? 32'd0 : (32'(cur) & 32'hFFFF_FFFC);
            if (burst == 2'b10)
                cur = base + ((cur - base + step) % wlen);
            else if (burst != 2'b00)
                cur = (cur + step) % 64'h1_0000_0000;
        end
    endtask

    task automatic start_ar(input int u, input logic [3:0] id, input logic [31:0] addr,
                            input logic [3:0] len, input logic [2:0] size, input logic [1:0] burst);
        int n;
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst;
        arvalid[u] = 1'b1;
        n = 0;
        while (arready[u] !== 1'b1 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk("arready_wait_timeout", 32'(n >= 50), 32'd0);
        @(posedge clk); #1;
        arvalid[u] = 1'b0;
        chk("arready_low_after_ar", 32'(arready[u]), 32'd0);
    endtask

    task automatic collect(input int u, input int bp, input int nexp, output int nb,
                           output int lat, output int stall_err, output int proto_err);
        int cyc;
        bit prev_v, prev_hs;
        logic [38:0] held, now_v;
        nb = 0; lat = -1; stall_err = 0; proto_err = 0;
        cyc = 0; prev_v = 1'b0; prev_hs = 1'b0; held = '0;
        while (nb < nexp && cyc < 200) begin
            if (bp == 0)      rready[u] = 1'b1;
            else if (bp == 1) rready[u] = (cyc % 2 == 0);
            else              rready[u] = ($urandom_range(0, 1) == 1);
            if (arready[u] !== 1'b0) proto_err++;
            if (lat >= 0 && rvalid[u] !== 1'b1) proto_err++;
            now_v = {rid[u], rdata[u], rresp[u], rlast[u]};
            if (rvalid[u] === 1'b1) begin
                if (lat < 0) lat = cyc;
                if (prev_v && !prev_hs && now_v !== held) stall_err++;
                held    = now_v;
                prev_hs = rready[u];
                if (rready[u]) begin
                    q_data.push_back(rdata[u]);
                    q_resp.push_back(rresp[u]);
                    q_last.push_back(rlast[u]);
                    q_id.push_back(rid[u]);
                    nb++;
                end
            end else begin
                prev_hs = 1'b0;
            end
            prev_v = (rvalid[u] === 1'b1);
            @(posedge clk); #1; cyc++;
        end
        rready[u] = 1'b0;
    endtask

    task automatic do_burst(input int u, input logic [3:0] id, input logic [31:0] addr,
                            input logic [3:0] len, input logic [2:0] size, input logic [1:0] burst,
                            input int bp, input string tag);
        int nb, lat, stall_err, proto_err;
        q_data.delete(); q_resp.delete(); q_last.delete(); q_id.delete();
        start_ar(u, id, addr, len, size, burst);
        collect(u, bp, e_beats, nb, lat, stall_err, proto_err);
        chk($sformatf("%s latency", tag), 32'(lat), 32'(1 + f_delay(u)));
        chk($sformatf("%s beats", tag), 32'(nb), 32'(e_beats));
        for (int b = 0; b < nb && b < e_beats; b++) begin
            chk($sformatf("%s beat%0d rdata", tag, b), q_data[b], e_data[b]);
            chk($sformatf("%s beat%0d rresp", tag, b), 32'(q_resp[b]), 32'(e_resp));
            chk($sformatf("%s beat%0d rlast", tag, b), 32'(q_last[b]), 32'(b == e_beats - 1));
            chk($sformatf("%s beat%0d rid", tag, b), 32'(q_id[b]), 32'(id));
        end
        chk($sformatf("%s stall_stable", tag), 32'(stall_err), 32'd0);
        chk($sformatf("%s protocol", tag), 32'(proto_err), 32'd0);
        chk($sformatf("%s rvalid_after_last", tag), 32'(rvalid[u]), 32'd0);
        chk($sformatf("%s arready_after_last", tag), 32'(arready[u]), 32'd1);
    endtask

    typedef struct {
        int               u;
        logic [3:0]       id;
        logic [31:0]      addr;
        logic [3:0]       len;
        logic [2:0]       size;
        logic [1:0]       burst;
        int               bp;
        int               nexp;
        logic [1:0]       resp;
        logic [3:0][31:0] exp;
    } vec_t;

    vec_t        vecs[8];
    logic [3:0]  wrap_lens[4];

    initial begin
        int n;
        rst_n = 1'b0; arvalid = 2'b00; rready = 2'b00;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0;
        wrap_lens = '{4'd1, 4'd3, 4'd7, 4'd15};

        vecs[0] = '{0, 4'h5, 32'h100, 4'd3, 3'd2, 2'b01, 0, 4, 2'b00, {32'h10C, 32'h108, 32'h104, 32'h100}};
        vecs[1] = '{0, 4'hA, 32'h38, 4'd3, 3'd2, 2'b10, 0, 4, 2'b00, {32'h34, 32'h30, 32'h3C, 32'h38}};
        vecs[2] = '{0, 4'h3, 32'h20, 4'd2, 3'd2, 2'b00, 1, 3, 2'b00, {32'h0, 32'h20, 32'h20, 32'h20}};
        vecs[3] = '{1, 4'h7, 32'h44, 4'd0, 3'd2, 2'b01, 0, 1, 2'b00, {32'h0, 32'h0, 32'h0, 32'h44}};
        vecs[4] = '{0, 4'hF, 32'h13, 4'd1, 3'd0, 2'b01, 0, 2, 2'b00, {32'h0, 32'h0, 32'h14, 32'h10}};
        vecs[5] = '{1, 4'h2, 32'hFFFF_FFFC, 4'd1, 3'd2, 2'b01, 1, 2, 2'b00, {32'h0, 32'h0, 32'h0, 32'hFFFF_FFFC}};
        vecs[6] = '{1, 4'h6, 32'h1C, 4'd1, 3'd2, 2'b10, 1, 2, 2'b00, {32'h0, 32'h0, 32'h18, 32'h1C}};
`ifdef AXI_RD_SLVERR_EN
        vecs[7] = '{0, 4'h9, 32'h40, 4'd1, 3'd3, 2'b01, 0, 2, 2'b10, {32'h0, 32'h0, 32'h0, 32'h0}};
`else
        vecs[7] = '{0, 4'h9, 32'h40, 4'd1, 3'd3, 2'b01, 0, 2, 2'b00, {32'h0, 32'h0, 32'h48, 32'h40}};
`endif

        // Reset values, then ARREADY on the first edge after release
        repeat (2) @(posedge clk);
        #1;
        for (int u = 0; u < 2; u++) begin
            chk($sformatf("rst u%0d arready", u), 32'(arready[u]), 32'd0);
            chk($sformatf("rst u%0d rvalid", u), 32'(rvalid[u]), 32'd0);
            chk($sformatf("rst u%0d rlast", u), 32'(rlast[u]), 32'd0);
            chk($sformatf("rst u%0d rresp", u), 32'(rresp[u]), 32'd0);
            chk($sformatf("rst u%0d rid", u), 32'(rid[u]), 32'd0);
            chk($sformatf("rst u%0d rdata", u), rdata[u], 32'd0);
        end
        rst_n = 1'b1;
        #1 chk("arready_before_first_edge", 32'(arready[0]), 32'd0);
        @(posedge clk); #1;
        chk("arready_first_edge u0", 32'(arready[0]), 32'd1);
        chk("arready_first_edge u1", 32'(arready[1]), 32'd1);

        for (int i = 0; i < 8; i++) begin
            for (int b = 0; b < 4; b++) e_data[b] = vecs[i].exp[b];
            e_beats = vecs[i].nexp;
            e_resp  = vecs[i].resp;
            do_burst(vecs[i].u, vecs[i].id, vecs[i].addr, vecs[i].len, vecs[i].size,
                     vecs[i].burst, vecs[i].bp, $sformatf("vec%0d", i));
        end

        // Reset pulsed while beat 2 of a 4-beat burst is on the bus
        start_ar(0, 4'h4, 32'h200, 4'd3, 3'd2, 2'b01);
        rready[0] = 1'b1;
        n = 0;
        while (rvalid[0] !== 1'b1 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk("midrst first beat rdata", rdata[0], 32'h200);
        @(posedge clk); #1;
        chk("midrst second beat rdata", rdata[0], 32'h204);
        rst_n = 1'b0;
        #1;
        chk("midrst rvalid", 32'(rvalid[0]), 32'd0);
        chk("midrst rdata", rdata[0], 32'd0);
        chk("midrst arready", 32'(arready[0]), 32'd0);
        rready[0] = 1'b0;
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("postrst arready", 32'(arready[0]), 32'd1);
        chk("postrst rvalid", 32'(rvalid[0]), 32'd0);
        e_beats = 2; e_resp = 2'b00; e_data[0] = 32'h300; e_data[1] = 32'h304;
        do_burst(0, 4'hC, 32'h300, 4'd1, 3'd2, 2'b01, 0, "postrst");

        // Randomized bursts with random backpressure against the reference model
        for (int t = 0; t < 40; t++) begin
            int u;
            logic [1:0]  burst;
            logic [2:0]  size;
            logic [3:0]  len;
            logic [31:0] addr;
            logic [3:0]  id;
            u     = int'($urandom_range(0, 1));
            burst = 2'($urandom_range(0, 3));
            size  = 3'($urandom_range(0, 3));
            len   = (burst == 2'b10) ? wrap_lens[$urandom_range(0, 3)] : 4'($urandom_range(0, 15));
            addr  = $urandom;
            id    = 4'($urandom);
            model(addr, len, size, burst);
            do_burst(u, id, addr, len, size, burst, 2, $sformatf("rnd%0d", t));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
